// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode/funct constants, ALU and error encodings, FSM state type
package ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LOAD  = 6'b000010;
    localparam logic [5:0] OP_STORE = 6'b000011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_MUL   = 6'b110010;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_MUL  = 3'd4;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, ERR} state_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational op/funct decode
// Ports: op, funct in; alu_op, alu_src, is_mul, is_load, is_store, illegal out.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       is_mul,
    output logic       is_load,
    output logic       is_store,
    output logic       illegal
);
    logic is_r;
    always_comb begin
        is_r     = op == OP_RTYPE;
        is_load  = op == OP_LOAD;
        is_store = op == OP_STORE;
        is_mul   = is_r && funct == FN_MUL;
        alu_src  = is_load || is_store;
        alu_op   = !is_r ? ALU_ADD :
                   funct == FN_SUB ? ALU_SUB :
                   funct == FN_AND ? ALU_AND :
                   funct == FN_OR  ? ALU_OR  :
                   funct == FN_MUL ? ALU_MUL : ALU_ADD;
        illegal  = !(is_r || is_load || is_store) ||
                   (is_r && !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_MUL}));
    end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction control FSM driving registered datapath controls
// Ports: clk, rst; instr_valid/instr/instr_ready handshake; mem_ready from data memory;
//        rs_addr, rt_addr, rd_addr, imm_ext, alu_op, alu_src, mult_start, mem_read,
//        mem_write, reg_write, wb_sel, done, error, err_code to the datapath.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MULT_LAT    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              mem_ready,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] imm_ext,
    output logic [2:0]        alu_op,
    output logic              alu_src,
    output logic              mult_start,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              wb_sel,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    state_t     state, nxt;
    logic [5:0] op, funct;
    logic [7:0] cnt;
    logic [2:0] d_alu_op;
    logic       d_alu_src, d_mul, d_load, d_store, d_illegal, accept;
    logic       unused_shamt;

    assign accept       = instr_valid && instr_ready;
    assign unused_shamt = ^instr[10:6];

    ctrl_decode u_dec (
        .op       (op),
        .funct    (funct),
        .alu_op   (d_alu_op),
        .alu_src  (d_alu_src),
        .is_mul   (d_mul),
        .is_load  (d_load),
        .is_store (d_store),
        .illegal  (d_illegal)
    );

    // cnt is shared: MUL hold count in EXEC, timeout count in MEM
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? DECODE : IDLE;
            DECODE:  nxt = d_illegal ? ERR : EXEC;
            EXEC:    nxt = d_mul && cnt != 8'd0 ? EXEC : d_load || d_store ? MEM : WB;
            MEM:     nxt = mem_ready ? WB : cnt == 8'd0 ? ERR : MEM;
            default: nxt = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            funct       <= '0;
            rs_addr     <= '0;
            rt_addr     <= '0;
            rd_addr     <= '0;
            imm_ext     <= '0;
            alu_op      <= '0;
            alu_src     <= 1'b0;
            instr_ready <= 1'b1;
            mult_start  <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            reg_write   <= 1'b0;
            wb_sel      <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state <= nxt;
            cnt   <= state == DECODE ? 8'(MULT_LAT - 1) :
                     state == EXEC && nxt == MEM ? 8'(MEM_TIMEOUT - 1) :
                     cnt != 8'd0 ? cnt - 8'd1 : cnt;
            if (accept) begin
                op      <= instr[31:26];
                funct   <= instr[5:0];
                rs_addr <= instr[25:21];
                rt_addr <= instr[20:16];
                rd_addr <= instr[31:26] == OP_LOAD ? instr[20:16] : instr[15:11];
                imm_ext <= DATA_W'($signed(instr[15:0]));
            end
            if (state == DECODE) begin
                alu_op  <= d_alu_op;
                alu_src <= d_alu_src;
            end
            instr_ready <= nxt == IDLE;
            mult_start  <= state == DECODE && nxt == EXEC && d_mul;
            mem_read    <= nxt == MEM && d_load;
            mem_write   <= nxt == MEM && d_store;
            reg_write   <= nxt == WB && !d_store;
            wb_sel      <= nxt == WB && d_load;
            done        <= nxt == WB;
            error       <= nxt == ERR;
            err_code    <= accept ? ERR_NONE :
                           nxt == ERR ? (state == MEM ? ERR_TIMEOUT : ERR_ILLEGAL) : err_code;
        end
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: self-checking bench for control_fsm against a cycle-timeline model
module tb_control_fsm;
    localparam int MULT_LAT    = 4;
    localparam int MEM_TIMEOUT = 16;

    logic        clk, rst, instr_valid, instr_ready, mem_ready;
    logic [31:0] instr, imm_ext;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [2:0]  alu_op;
    logic        alu_src, mult_start, mem_read, mem_write, reg_write, wb_sel, done, error;
    logic [1:0]  err_code;

    control_fsm #(.DATA_W(32), .MULT_LAT(MULT_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .imm_ext(imm_ext), .alu_op(alu_op),
        .alu_src(alu_src), .mult_start(mult_start), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel), .done(done),
        .error(error), .err_code(err_code)
    );

    typedef struct packed {
        logic       busy, rdy, dn, er, mr, mw, rw, ws, ms, ctl, asrc;
        logic [1:0] ec;
        logic [2:0] aop;
    } exp_t;

    exp_t        q[$];
    exp_t        ce;
    logic [1:0]  idle_ec = 2'd0;
    logic [4:0]  cur_rs, cur_rt, cur_rd, rd_d;
    logic [31:0] cur_imm, imm_d;
    logic [2:0]  aop_d;
    logic [1:0]  ec_d;
    logic        ws_d;
    int          n_chk = 0, n_err = 0, cyc = 0, acc = 0, chk_on = 0;
    int          done_cyc, err_cyc, ms_cyc, n_done, n_erp, n_ms, n_mr, n_mw, n_rw;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic clr();
        n_done = 0; n_erp = 0; n_ms = 0; n_mr = 0; n_mw = 0; n_rw = 0;
        done_cyc = -1; err_cyc = -1; ms_cyc = -1;
    endtask

    // Builds the expected per-cycle outputs from DECODE until the return to IDLE.
    task automatic plan(input logic [31:0] ins, input int wait_n, output int len, output int mem_at);
        logic [5:0] op, fn;
        logic [2:0] a;
        bit         r, ld, st, mul, legal;
        int         ex, n;
        exp_t       e;
        op = ins[31:26];
        fn = ins[5:0];
        r  = op == 6'd1;
        ld = op == 6'd2;
        st = op == 6'd3;
        case (fn)
            6'h20: a = 3'd0;
            6'h22: a = 3'd1;
            6'h24: a = 3'd2;
            6'h25: a = 3'd3;
            6'h32: a = 3'd4;
            default: a = 3'd7;
        endcase
        legal = ld || st || (r && a != 3'd7);
        mul   = r && a == 3'd4;
        if (!r) a = 3'd0;
        cur_rs  = ins[25:21];
        cur_rt  = ins[20:16];
        cur_rd  = ld ? ins[20:16] : ins[15:11];
        cur_imm = {{16{ins[15]}}, ins[15:0]};
        ex      = mul ? MULT_LAT : 1;
        mem_at  = 2 + ex;
        len     = 0;
        e       = '0;
        e.busy  = 1'b1;
        q.push_back(e); len++;
        if (!legal) begin
            e.er = 1'b1; e.ec = 2'd1;
            q.push_back(e); len++;
            return;
        end
        e.ctl = 1'b1; e.aop = a; e.asrc = ld || st;
        for (int i = 0; i < ex; i++) begin
            e.ms = mul && i == 0;
            q.push_back(e); len++;
        end
        e.ms = 1'b0;
        if (ld || st) begin
            n = wait_n < MEM_TIMEOUT ? wait_n + 1 : MEM_TIMEOUT;
            e.mr = ld; e.mw = st;
            repeat (n) begin q.push_back(e); len++; end
            e.mr = 1'b0; e.mw = 1'b0;
            if (wait_n >= MEM_TIMEOUT) begin
                e.er = 1'b1; e.ec = 2'd2;
                q.push_back(e); len++;
                return;
            end
        end
        e.dn = 1'b1; e.rw = !st; e.ws = ld;
        q.push_back(e); len++;
    endtask

    // wait_n: MEM cycles with mem_ready low before it rises; early: mem_ready high before MEM;
    // noise: keep instr_valid high with another instruction while busy.
    task automatic run(input logic [31:0] ins, input int wait_n, input bit early, input bit noise);
        int len, mem_at;
        clr();
        instr_valid = 1'b1;
        instr       = ins;
        acc         = cyc;
        @(posedge clk); #1;
        plan(ins, wait_n, len, mem_at);
        for (int k = 1; k <= len; k++) begin
            instr_valid = noise;
            instr       = 32'h04434820;
            mem_ready   = (k == mem_at + wait_n) || (early && k < mem_at);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on != 0) begin
            if (q.size() > 0) ce = q.pop_front();
            else begin
                ce     = '0;
                ce.rdy = 1'b1;
                ce.ec  = idle_ec;
            end
            idle_ec = ce.ec;
            chk("instr_ready", instr_ready, ce.rdy);
            chk("done", done, ce.dn);
            chk("error", error, ce.er);
            chk("err_code", err_code, ce.ec);
            chk("mem_read", mem_read, ce.mr);
            chk("mem_write", mem_write, ce.mw);
            chk("reg_write", reg_write, ce.rw);
            chk("wb_sel", wb_sel, ce.ws);
            chk("mult_start", mult_start, ce.ms);
            if (ce.busy) begin
                chk("rs_addr", rs_addr, cur_rs);
                chk("rt_addr", rt_addr, cur_rt);
                chk("rd_addr", rd_addr, cur_rd);
                chk("imm_ext", imm_ext, cur_imm);
            end
            if (ce.ctl) begin
                chk("alu_op", alu_op, ce.aop);
                chk("alu_src", alu_src, ce.asrc);
            end
            if (done) begin n_done++; done_cyc = cyc; rd_d = rd_addr; imm_d = imm_ext; aop_d = alu_op; ws_d = wb_sel; end
            if (error) begin n_erp++; err_cyc = cyc; ec_d = err_code; imm_d = imm_ext; end
            if (mult_start) begin n_ms++; ms_cyc = cyc; end
            n_mr += int'(mem_read);
            n_mw += int'(mem_write);
            n_rw += int'(reg_write);
            if (rst) begin
                q.delete();
                idle_ec = 2'd0;
            end
        end
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0;
        clr();
        repeat (2) @(posedge clk); #1;
        chk("reset_instr_ready", instr_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_err_code", err_code, 0);
        chk("reset_mem_read", mem_read, 0);
        rst = 1'b0;
        chk_on = 1;
        @(posedge clk); #1;

        run(32'h08A01900, 2, 0, 1);
        chk("load_done_latency", done_cyc - acc, 6);
        chk("load_mem_read_cycles", n_mr, 3);
        chk("load_rd", rd_d, 0);
        chk("load_imm", imm_d, 32'h00001900);
        chk("load_wb_sel", ws_d, 1);

        run(32'h040142B2, 0, 0, 1);
        chk("mul_start_latency", ms_cyc - acc, 2);
        chk("mul_start_count", n_ms, 1);
        chk("mul_done_latency", done_cyc - acc, 6);
        chk("mul_rd", rd_d, 8);
        chk("mul_alu_op", aop_d, 4);

        run(32'h04434820, 0, 0, 0);
        chk("add_done_latency", done_cyc - acc, 3);
        chk("add_rd", rd_d, 9);
        chk("add_alu_op", aop_d, 0);
        run(32'h050952A2, 0, 0, 0);
        chk("sub_done_latency", done_cyc - acc, 3);
        chk("sub_rd", rd_d, 10);
        chk("sub_alu_op", aop_d, 1);

        run(32'h0CAAFFFC, 99, 0, 1);
        chk("store_err_latency", err_cyc - acc, 19);
        chk("store_err_code", ec_d, 2);
        chk("store_mem_write_cycles", n_mw, 16);
        chk("store_done_count", n_done, 0);
        chk("store_imm", imm_d, 32'hFFFFFFFC);

        run(32'h0443483F, 0, 0, 1);
        chk("bad_funct_err_latency", err_cyc - acc, 2);
        chk("bad_funct_err_code", ec_d, 1);
        chk("bad_funct_strobes", n_rw + n_mr + n_mw, 0);

        run(32'h00434820, 0, 0, 0);
        chk("bad_op_err_latency", err_cyc - acc, 2);
        chk("bad_op_err_code", ec_d, 1);

        run(32'h08A01900, MEM_TIMEOUT - 1, 0, 0);
        chk("load_last_cycle_done_latency", done_cyc - acc, 19);
        chk("load_last_cycle_mem_read", n_mr, 16);
        chk("load_last_cycle_errors", n_erp, 0);

        run(32'h08A01900, 1, 1, 0);
        chk("load_early_ready_latency", done_cyc - acc, 5);
        run(32'h04434825, 0, 1, 0);
        chk("or_early_ready_latency", done_cyc - acc, 3);
        run(32'h04434824, 0, 0, 0);
        chk("and_alu_op", aop_d, 2);

        begin
            int len, mem_at;
            clr();
            instr_valid = 1'b1;
            instr       = 32'h040142B2;
            acc         = cyc;
            @(posedge clk); #1;
            plan(32'h040142B2, 0, len, mem_at);
            instr_valid = 1'b0;
            repeat (2) @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (2) @(posedge clk); #1;
            chk("rst_mid_mul_done", n_done, 0);
            chk("rst_mid_mul_reg_write", n_rw, 0);
            chk("rst_mid_mul_ready", instr_ready, 1);
        end
        run(32'h04434820, 0, 0, 0);
        chk("add_after_rst_latency", done_cyc - acc, 3);

        repeat (3) @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
